// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin mux arbiter family.
package mux_pkg;
  localparam int NUM_REQ_DEF   = 4;
  localparam int SEL_WIDTH_DEF = 2;

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;

  // Index of the set bit of a one-hot vector (up to 16 requesters).
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (oh[i]) idx = idx | 4'(i);
    return idx;
  endfunction
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/data in, grant/select/enable out bundle of the mux arbiter.
interface mux_rr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int SEL_WIDTH = 2
);
  logic [NUM_REQ-1:0]   Request_In;
  logic [NUM_REQ-1:0]   Data_In;
  logic [NUM_REQ-1:0]   Grant_Out;
  logic [SEL_WIDTH-1:0] Select_Out;
  logic                 Enable_Out;

  modport master (output Request_In, Data_In, input Grant_Out, Select_Out, Enable_Out);
  modport slave  (input Request_In, Data_In, output Grant_Out, Select_Out, Enable_Out);
endinterface

// File: rtl/mux_rr_arbiter_rr_next_winner.sv
// Combinational round-robin search: first set request after ptr_i, wrapping.
module rr_next_winner
  import mux_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int SEL_WIDTH = SEL_WIDTH_DEF
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic                 found_o,
  output logic [SEL_WIDTH-1:0] idx_o,
  output logic [NUM_REQ-1:0]   onehot_o
);
  logic [SEL_WIDTH-1:0] cand;

  // NUM_REQ is a power of two, so the select-width add wraps for free.
  always_comb begin
    onehot_o = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ptr_i + SEL_WIDTH'(i);
      if (onehot_o == '0 && req_i[cand]) onehot_o[cand] = 1'b1;
    end
  end

  assign found_o = |onehot_o;
  assign idx_o   = SEL_WIDTH'(onehot_to_idx(16'(onehot_o)));
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 1-bit mux line with bounded tenure.
module mux_rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int SEL_WIDTH  = SEL_WIDTH_DEF,
  parameter int MAX_HOLD   = 8,
  parameter int HOLD_WIDTH = 8
) (
  input  logic        Clock_In,
  input  logic        Reset_N_In,
  mux_rr_arbiter_if.slave bus,
  output wire logic   MUX_Data_Out
);
  localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = HOLD_WIDTH'(MAX_HOLD);
  localparam logic [HOLD_WIDTH-1:0] HOLD_ONE = HOLD_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0]  PTR_RST  = SEL_WIDTH'(NUM_REQ - 1);

  state_e                state_q;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic                  en_q;
  logic [HOLD_WIDTH-1:0] cnt_q;
  logic [SEL_WIDTH-1:0]  ptr_q;

  logic                  idle_found_d, hand_found_d;
  logic [SEL_WIDTH-1:0]  idle_idx_d,   hand_idx_d;
  logic [NUM_REQ-1:0]    idle_oh_d,    hand_oh_d;
  logic [NUM_REQ-1:0]    others_req;
  logic                  own_req;

  assign others_req = bus.Request_In & ~gnt_q;
  assign own_req    = |(bus.Request_In & gnt_q);

  rr_next_winner #(.NUM_REQ(NUM_REQ), .SEL_WIDTH(SEL_WIDTH)) u_idle_search (
    .req_i(bus.Request_In), .ptr_i(ptr_q),
    .found_o(idle_found_d), .idx_o(idle_idx_d), .onehot_o(idle_oh_d)
  );

  // Owner masked out, so one search serves both release and timeout handoff.
  rr_next_winner #(.NUM_REQ(NUM_REQ), .SEL_WIDTH(SEL_WIDTH)) u_hand_search (
    .req_i(others_req), .ptr_i(sel_q),
    .found_o(hand_found_d), .idx_o(hand_idx_d), .onehot_o(hand_oh_d)
  );

  always_ff @(posedge Clock_In) begin
    if (!Reset_N_In) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (idle_found_d) begin
            state_q <= ST_GRANT;
            gnt_q   <= idle_oh_d;
            sel_q   <= idle_idx_d;
            en_q    <= 1'b1;
            cnt_q   <= HOLD_ONE;
          end
        end
        ST_GRANT: begin
          if (!own_req) begin
            ptr_q <= sel_q;
            if (hand_found_d) begin
              gnt_q <= hand_oh_d;
              sel_q <= hand_idx_d;
              cnt_q <= HOLD_ONE;
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= '0;
              sel_q   <= '0;
              en_q    <= 1'b0;
              cnt_q   <= '0;
            end
          end else if (cnt_q >= HOLD_MAX) begin
            // Tenure expired: hand off if anyone waits, else restart the window.
            cnt_q <= HOLD_ONE;
            if (hand_found_d) begin
              ptr_q <= sel_q;
              gnt_q <= hand_oh_d;
              sel_q <= hand_idx_d;
            end
          end else begin
            cnt_q <= cnt_q + HOLD_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          sel_q   <= '0;
          en_q    <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.Grant_Out  = gnt_q;
  assign bus.Select_Out = sel_q;
  assign bus.Enable_Out = en_q;
  assign MUX_Data_Out   = en_q ? bus.Data_In[sel_q] : 1'bz;
endmodule
